// File: rtl/anomaly_removal.sv
// anomaly_removal: per-pixel difference mask for the X-ray anomaly path.
// Pixels whose |anomaly - original| is within THRESHOLD are replaced by
// FILL_VALUE; all other pixels pass the anomaly pixel through unchanged.
// One pixel pair per clock, single-cycle registered latency, no stalls.
module anomaly_removal #(
  parameter int unsigned               DATA_WIDTH = 8,
  parameter int unsigned               THRESHOLD  = 0,
  parameter logic [DATA_WIDTH-1:0]     FILL_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] original_pixel,
  input  logic [DATA_WIDTH-1:0] anomaly_pixel,
  output logic [DATA_WIDTH-1:0] modified_pixel
);

  // One extra bit so the magnitude never wraps (0x00 vs 0xFF -> 255).
  logic [DATA_WIDTH:0]   orig_ext;
  logic [DATA_WIDTH:0]   anom_ext;
  logic [DATA_WIDTH:0]   diff;
  logic                  is_equal;
  logic [DATA_WIDTH-1:0] modified_pixel_d;
  logic [DATA_WIDTH-1:0] modified_pixel_q;

  // Unsigned absolute difference and mask selection.
  always_comb begin
    orig_ext         = {1'b0, original_pixel};
    anom_ext         = {1'b0, anomaly_pixel};
    diff             = (anom_ext >= orig_ext) ? (anom_ext - orig_ext)
                                              : (orig_ext - anom_ext);
    // Compare at 32 bits so any THRESHOLD (even >= 2^DATA_WIDTH) is honoured.
    is_equal         = (32'(diff) <= THRESHOLD);
    modified_pixel_d = is_equal ? FILL_VALUE : anomaly_pixel;
  end

  // Output register; reset drives a defined zero immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) modified_pixel_q <= '0;
    else     modified_pixel_q <= modified_pixel_d;
  end

  assign modified_pixel = modified_pixel_q;

endmodule

// File: tb/tb_anomaly_removal.sv
// Directed bench for anomaly_removal: default-parameter DUT plus a
// THRESHOLD=4 instance sharing the same stimulus.
module tb_anomaly_removal;

  logic       clk;
  logic       rst;
  logic [7:0] orig;
  logic [7:0] anom;
  logic [7:0] mod_d0;
  logic [7:0] mod_t4;

  int n_vec;
  int n_err;

  anomaly_removal #(.DATA_WIDTH(8), .THRESHOLD(0), .FILL_VALUE(8'h00)) dut (
    .clk            (clk),
    .rst            (rst),
    .original_pixel (orig),
    .anomaly_pixel  (anom),
    .modified_pixel (mod_d0)
  );

  anomaly_removal #(.DATA_WIDTH(8), .THRESHOLD(4), .FILL_VALUE(8'h00)) dut_t (
    .clk            (clk),
    .rst            (rst),
    .original_pixel (orig),
    .anomaly_pixel  (anom),
    .modified_pixel (mod_t4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on negedges; outputs are sampled on the following negedge.
  task automatic test_reset();
    rst  = 1'b1;
    orig = 8'h12;
    anom = 8'h34;
    #1;
    n_vec++;
    if (mod_d0 !== 8'h00) begin
      n_err++; $display("FAIL reset_async: got %h want 00", mod_d0);
    end
    n_vec++;
    if (mod_t4 !== 8'h00) begin
      n_err++; $display("FAIL reset_async_t4: got %h want 00", mod_t4);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (mod_d0 !== 8'h00) begin
      n_err++; $display("FAIL reset_hold: got %h want 00", mod_d0);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mod_d0 !== 8'h34) begin
      n_err++; $display("FAIL reset_release: got %h want 34", mod_d0);
    end
  endtask

  task automatic test_equal();
    logic [7:0] tv [3] = '{8'h5A, 8'h00, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      orig = tv[i];
      anom = tv[i];
      @(negedge clk);
      n_vec++;
      if (mod_d0 !== 8'h00) begin
        n_err++; $display("FAIL equal_%h: got %h want 00", tv[i], mod_d0);
      end
    end
  endtask

  task automatic test_differ();
    logic [7:0] to [3] = '{8'h10, 8'hFF, 8'h00};
    logic [7:0] ta [3] = '{8'h80, 8'h00, 8'hFF};
    logic [7:0] te [3] = '{8'h80, 8'h00, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      orig = to[i];
      anom = ta[i];
      @(negedge clk);
      n_vec++;
      if (mod_d0 !== te[i]) begin
        n_err++;
        $display("FAIL differ_%h_%h: got %h want %h", to[i], ta[i], mod_d0, te[i]);
      end
    end
  endtask

  // 100 back-to-back pairs; every third pair is deliberately equal.
  task automatic test_back_to_back();
    logic [7:0] exp_prev;
    logic [7:0] o;
    logic [7:0] a;
    exp_prev = 8'h00;
    for (int k = 0; k <= 100; k++) begin
      if (k > 0) begin
        n_vec++;
        if (mod_d0 !== exp_prev) begin
          n_err++;
          $display("FAIL stream_%0d: got %h want %h", k - 1, mod_d0, exp_prev);
        end
      end
      if (k < 100) begin
        o = 8'($urandom_range(0, 255));
        a = (k % 3 == 0) ? o : 8'($urandom_range(0, 255));
        orig = o;
        anom = a;
        exp_prev = (o == a) ? 8'h00 : a;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    orig = 8'h21;
    anom = 8'h99;
    @(negedge clk);
    n_vec++;
    if (mod_d0 !== 8'h99) begin
      n_err++; $display("FAIL midrst_pre: got %h want 99", mod_d0);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (mod_d0 !== 8'h00) begin
      n_err++; $display("FAIL midrst_async: got %h want 00", mod_d0);
    end
    @(negedge clk);
    n_vec++;
    if (mod_d0 !== 8'h00) begin
      n_err++; $display("FAIL midrst_hold: got %h want 00", mod_d0);
    end
    rst  = 1'b0;
    orig = 8'h30;
    anom = 8'h31;
    @(negedge clk);
    n_vec++;
    if (mod_d0 !== 8'h31) begin
      n_err++; $display("FAIL midrst_resume: got %h want 31", mod_d0);
    end
    n_vec++;
    if (mod_t4 !== 8'h00) begin
      n_err++; $display("FAIL midrst_resume_t4: got %h want 00", mod_t4);
    end
  endtask

  task automatic test_threshold();
    logic [7:0] to [5] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h00};
    logic [7:0] ta [5] = '{8'h44, 8'h45, 8'h3C, 8'h3B, 8'hFF};
    logic [7:0] te [5] = '{8'h00, 8'h45, 8'h00, 8'h3B, 8'hFF};
    for (int i = 0; i < 5; i++) begin
      orig = to[i];
      anom = ta[i];
      @(negedge clk);
      n_vec++;
      if (mod_t4 !== te[i]) begin
        n_err++;
        $display("FAIL thr4_%h_%h: got %h want %h", to[i], ta[i], mod_t4, te[i]);
      end
      // Default instance masks only exact equality, so all of these pass through.
      n_vec++;
      if (mod_d0 !== ta[i]) begin
        n_err++;
        $display("FAIL thr0_%h_%h: got %h want %h", to[i], ta[i], mod_d0, ta[i]);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    orig  = 8'h00;
    anom  = 8'h00;
    test_reset();
    test_equal();
    test_differ();
    test_back_to_back();
    test_mid_reset();
    test_threshold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
